gen3_block_scheduler: RTL and testbench

Sequences the 128b/130b transmit datapath on clk_8G and shares it among three block sources: data, ordered-set and periodic SKP. Runs the 130-cycle block frame:
- drives tx_start for the 2 sync-header cycles;
- drives k to select the header type;
- drives tx_valid for the 128 payload cycles.
All outputs feed header_synchronizer / fifo_sync / sync_head_add in the serializer top. Grants one requester per block; back-to-back blocks have no gap cycles.

---
 rtl/gen3_block_scheduler.sv | 149 ++++++++++++++
 tb/tb_gen3_block_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen3_block_scheduler.sv
// gen3_block_scheduler
//   Frames the 128b/130b transmit datapath on clk_8G and shares it among
//   three block sources (data, ordered-set, periodic SKP). Each block is
//   2 sync-header cycles (H0, H1) followed by PAYLOAD_BITS payload cycles;
//   consecutive blocks abut with no gap cycles.
//
//   Build option: define SKP_SCHED_EN to include the periodic SKP counter,
//   skp_pending and skp_gnt. Without it, skp_pending/skp_gnt are 0 and
//   arbitration is os_req > data_req.
//
// Ports
//   clk_8G       in   bit-rate clock
//   rst_8G       in   synchronous active-high reset
//   link_en      in   1 = scheduling allowed; 0 = finish block then idle
//   data_req     in   data block ready (level)
//   os_req       in   ordered-set block ready (level)
//   tx_start     out  high in both sync-header cycles
//   k            out  1 = ordered-set/SKP block, 0 = data block
//   tx_valid     out  high in payload cycles
//   data_gnt     out  pulse in H0 of a data block
//   os_gnt       out  pulse in H0 of an ordered-set block
//   skp_gnt      out  pulse in H0 of a SKP block
//   blk_active   out  high in H0, H1 and payload
//   skp_pending  out  SKP due, not yet issued
module gen3_block_scheduler #(
   parameter int unsigned PAYLOAD_BITS = 128,
   parameter int unsigned SKP_INTERVAL = 370,
   parameter int unsigned CNT_W        = 10
) (
   input  logic clk_8G,
   input  logic rst_8G,
   input  logic link_en,
   input  logic data_req,
   input  logic os_req,
   output logic tx_start,
   output logic k,
   output logic tx_valid,
   output logic data_gnt,
   output logic os_gnt,
   output logic skp_gnt,
   output logic blk_active,
   output logic skp_pending
);

   localparam int unsigned BIT_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_H0, S_H1, S_PAYLOAD} state_t;
   typedef enum logic [1:0] {T_DATA, T_OS, T_SKP} blk_t;

   state_t           state_q, state_d;
   blk_t             typ_q, typ_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             last_pay;
   logic             skp_due;

   assign last_pay = (state_q == S_PAYLOAD) && (bit_cnt_q == LAST_BIT);

`ifdef SKP_SCHED_EN
   localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);

   logic [CNT_W-1:0] skp_cnt_q;
   logic             skp_pending_q;
   logic             cnt_inc;
   logic             cnt_wrap;

   assign cnt_inc  = last_pay && (typ_q != T_SKP);
   assign cnt_wrap = cnt_inc && (skp_cnt_q == SKP_LAST);
   // The wrap is folded into this edge's arbitration so the SKP block
   // immediately follows the block that made it due.
   assign skp_due  = skp_pending_q || cnt_wrap;

   always_ff @(posedge clk_8G) begin
      if (rst_8G) begin
         skp_cnt_q     <= '0;
         skp_pending_q <= 1'b0;
      end else if (state_q == S_H0 && typ_q == T_SKP) begin
         skp_cnt_q     <= '0;
         skp_pending_q <= 1'b0;
      end else if (cnt_wrap) begin
         skp_cnt_q     <= '0;
         skp_pending_q <= 1'b1;
      end else if (cnt_inc) begin
         skp_cnt_q     <= skp_cnt_q + CNT_W'(1);
      end
   end

   assign skp_pending = skp_pending_q;
   assign skp_gnt     = (state_q == S_H0) && (typ_q == T_SKP);
`else
   logic unused_cfg;
   assign unused_cfg  = ^(SKP_INTERVAL + CNT_W);
   assign skp_due     = 1'b0;
   assign skp_pending = 1'b0;
   assign skp_gnt     = 1'b0;
`endif

   always_ff @(posedge clk_8G) begin
      if (rst_8G) begin
         state_q   <= S_IDLE;
         typ_q     <= T_DATA;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         typ_q     <= typ_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      typ_d     = typ_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         S_H0: state_d = S_H1;
         S_H1: begin
            state_d   = S_PAYLOAD;
            bit_cnt_d = '0;
         end
         default: begin
            // IDLE, or PAYLOAD: arbitrate only on the last payload cycle
            if (state_q == S_PAYLOAD && !last_pay) begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else if (link_en && skp_due) begin
               state_d = S_H0;
               typ_d   = T_SKP;
            end else if (link_en && os_req) begin
               state_d = S_H0;
               typ_d   = T_OS;
            end else if (link_en && data_req) begin
               state_d = S_H0;
               typ_d   = T_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      blk_active = (state_q != S_IDLE);
      tx_start   = (state_q == S_H0) || (state_q == S_H1);
      tx_valid   = (state_q == S_PAYLOAD);
      k          = blk_active && (typ_q != T_DATA);
      data_gnt   = (state_q == S_H0) && (typ_q == T_DATA);
      os_gnt     = (state_q == S_H0) && (typ_q == T_OS);
   end

endmodule

// File: tb/tb_gen3_block_scheduler.sv
module tb_gen3_block_scheduler;

   localparam int PB   = 128;
   localparam int SKPI = 4;
`ifdef SKP_SCHED_EN
   localparam bit SKP_ON = 1'b1;
`else
   localparam bit SKP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1, link = 1'b0, dreq = 1'b0, oreq = 1'b0;
   logic tx_start, k, tx_valid, data_gnt, os_gnt, skp_gnt, blk_active, skp_pending;

   gen3_block_scheduler #(.PAYLOAD_BITS(PB), .SKP_INTERVAL(SKPI), .CNT_W(10)) dut (
      .clk_8G(clk), .rst_8G(rst), .link_en(link), .data_req(dreq), .os_req(oreq),
      .tx_start(tx_start), .k(k), .tx_valid(tx_valid), .data_gnt(data_gnt),
      .os_gnt(os_gnt), .skp_gnt(skp_gnt), .blk_active(blk_active), .skp_pending(skp_pending)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference: a block is a position 0..PB+1 within a frame of a given kind.
   bit m_active = 0;
   int m_pos    = 0;
   int m_type   = 0;   // 0 data, 1 ordered set, 2 SKP
   int m_blocks = 0;   // completed non-SKP blocks since last SKP
   bit m_pend   = 0;

   function automatic logic [7:0] outs();
      return {tx_start, k, tx_valid, data_gnt, os_gnt, skp_gnt, blk_active, skp_pending};
   endfunction

   function automatic logic [7:0] model_outs();
      logic [7:0] v;
      v[7] = m_active && m_pos < 2;
      v[6] = m_active && m_type != 0;
      v[5] = m_active && m_pos >= 2;
      v[4] = m_active && m_pos == 0 && m_type == 0;
      v[3] = m_active && m_pos == 0 && m_type == 1;
      v[2] = m_active && m_pos == 0 && m_type == 2;
      v[1] = m_active;
      v[0] = m_pend;
      return v;
   endfunction

   task automatic model_step();
      bit done, due;
      if (rst) begin
         m_active = 0; m_pos = 0; m_type = 0; m_blocks = 0; m_pend = 0;
         return;
      end
      done = m_active && m_pos == PB + 1;
      if (SKP_ON && done && m_type != 2) begin
         m_blocks++;
         if (m_blocks == SKPI) begin
            m_blocks = 0;
            m_pend = 1;
         end
      end
      due = m_pend;
      if (m_active && m_pos == 0 && m_type == 2) begin
         m_pend = 0;
         m_blocks = 0;
      end
      if (!m_active || done) begin
         if (link && (due || oreq || dreq)) begin
            m_active = 1;
            m_pos = 0;
            m_type = due ? 2 : (oreq ? 1 : 0);
         end else begin
            m_active = 0;
         end
      end else begin
         m_pos++;
      end
   endtask

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One clock: advance the reference with the inputs seen at this edge,
   // then compare all outputs just after the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check8("model", outs(), model_outs());
   endtask

   task automatic start(input logic d, input logic o);
      rst = 1; link = 1; dreq = d; oreq = o;
      tick(); tick();
      rst = 0;
   endtask

   typedef struct {
      logic       r, l, d, o;
      logic [7:0] exp;
   } vec_t;

   vec_t vt[6];
   int cnt_ts, cnt_tv, cnt_dg, bad_ts, nz;

   initial begin
      // Reset priority and first data block, one edge per record
      vt[0] = '{1, 1, 1, 0, 8'b0000_0000};
      vt[1] = '{1, 1, 1, 0, 8'b0000_0000};
      vt[2] = '{1, 1, 1, 0, 8'b0000_0000};
      vt[3] = '{0, 1, 1, 0, 8'b1001_0010};
      vt[4] = '{0, 1, 0, 0, 8'b1000_0010};
      vt[5] = '{0, 1, 0, 0, 8'b0010_0010};
      #2;
      for (int i = 0; i < 6; i++) begin
         rst = vt[i].r; link = vt[i].l; dreq = vt[i].d; oreq = vt[i].o;
         tick();
         check8($sformatf("vec%0d", i), outs(), vt[i].exp);
      end
      cnt_tv = 1;
      for (int t = 0; t < 130; t++) begin
         tick();
         if (tx_valid) cnt_tv++;
      end
      check_int("first_blk_payload", cnt_tv, PB);

      // Back-to-back data blocks
      start(1, 0);
      cnt_ts = 0; cnt_tv = 0; cnt_dg = 0; bad_ts = 0;
      for (int t = 0; t < 390; t++) begin
         tick();
         if (tx_start) cnt_ts++;
         if (tx_valid) cnt_tv++;
         if (data_gnt) cnt_dg++;
         if (tx_start != ((t % 130) < 2)) bad_ts++;
         if (blk_active !== 1'b1) bad_ts++;
      end
      check_int("b2b_tx_start", cnt_ts, 6);
      check_int("b2b_pattern_err", bad_ts, 0);
      check_int("b2b_tx_valid", cnt_tv, 3 * PB);
      check_int("b2b_data_gnt", cnt_dg, 3);

      // Simultaneous requests: OS first, then data
      start(1, 1);
      tick();
      check8("simul_os", outs(), 8'b1100_1010);
      oreq = 0;
      for (int t = 0; t < 129; t++) tick();
      tick();
      check8("simul_data", outs(), 8'b1001_0010);

`ifdef SKP_SCHED_EN
      // SKP after 4 data blocks, beating a pending OS request
      start(1, 0);
      for (int t = 1; t <= 700; t++) begin
         if (t == 400) oreq = 1;
         tick();
         if (t == 520) check_int("skp_not_yet", int'(skp_pending), 0);
         if (t == 521) check8("skp_blk5", outs(), 8'b1100_0111);
         if (t == 522) check8("skp_cleared", outs(), 8'b1100_0010);
         if (t == 651) begin
            check8("os_blk6", outs(), 8'b1100_1010);
            oreq = 0;
         end
      end
`endif

      // Graceful stop: link_en drops at payload cycle 50
      start(1, 0);
      cnt_tv = 0; nz = 0;
      for (int t = 1; t <= 160; t++) begin
         tick();
         if (tx_valid) cnt_tv++;
         if (t > 130 && outs()[7:1] != 7'd0) nz++;
         if (t == 53) link = 0;
      end
      check_int("stop_payload", cnt_tv, PB);
      check_int("stop_idle_nonzero", nz, 0);

      // Mid-block reset at payload cycle 64
      start(1, 0);
      for (int t = 1; t <= 67; t++) tick();
      rst = 1;
      tick();
      check8("midrst_zero", outs(), 8'b0000_0000);
      rst = 0;
      tick();
      check8("midrst_h0", outs(), 8'b1001_0010);
      cnt_tv = 0;
      for (int t = 0; t < 129; t++) begin
         tick();
         if (tx_valid) cnt_tv++;
      end
      check_int("midrst_payload", cnt_tv, PB);

      // Randomized traffic against the reference
      for (int t = 0; t < 4000; t++) begin
         rst  = ($urandom % 600) == 0;
         if (($urandom % 200) == 0) link = ~link;
         if (($urandom % 40) == 0) dreq = ~dreq;
         if (($urandom % 60) == 0) oreq = ~oreq;
         tick();
         if (os_gnt && ($urandom % 2) == 0) oreq = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
